bist_pattern_gen: RTL and testbench

BIST_PATTERN_GEN -- requirements
Module: bist_pattern_gen

---
 rtl/bist_pkg.sv | 20 ++
 rtl/bist_lfsr.sv | 37 +++
 rtl/bist_pattern_gen.sv | 108 ++++++++++
 tb/tb_bist_pattern_gen.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared BIST definitions: FSM states, LFSR width default, polynomial taps and next-state function.
package bist_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEED = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } bist_state_t;

   localparam int unsigned LFSR_W_DEF = 16;

   // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from bits 15, 13, 12, 10
   localparam logic [LFSR_W_DEF-1:0] TAP_MASK = 16'hB400;

   function automatic logic [LFSR_W_DEF-1:0] lfsr_next(input logic [LFSR_W_DEF-1:0] v);
      return {v[LFSR_W_DEF-2:0], ^(v & TAP_MASK)};
   endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Fibonacci shift register with load and step enable; din is folded into bit 0 so the
// same block serves as a pattern LFSR (din tied low) and as a MISR.
module bist_lfsr
   import bist_pkg::*;
#(
   parameter int unsigned W       = LFSR_W_DEF,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         step,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         din,
   output logic [W-1:0] q
);

   logic [W-1:0] nxt;

   generate
      if (W == LFSR_W_DEF) begin : g_pkg_fn
         always_comb nxt = lfsr_next(q);
      end else begin : g_generic
         always_comb nxt = {q[W-2:0], ^(q & W'(TAP_MASK))};
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= RST_VAL;
      else if (load)
         q <= load_val;
      else if (step)
         q <= nxt ^ {{(W-1){1'b0}}, din};
   end

endmodule

// File: rtl/bist_pattern_gen.sv
// BIST stimulus generator with valid/ready pattern handshake.
// Optional response MISR is built when the macro BIST_MISR_EN is defined.
module bist_pattern_gen
   import bist_pkg::*;
#(
   parameter int unsigned LFSR_W = LFSR_W_DEF,
   parameter int unsigned PAT_W  = 5
) (
   input  logic              I1470_clk,
   input  logic              I1477_rst,
   input  logic              start,
   input  logic [LFSR_W-1:0] seed,
   input  logic [15:0]       num_patterns,
   output logic [PAT_W-1:0]  pat_data,
   output logic              pat_valid,
   input  logic              pat_ready,
   output logic              busy,
`ifdef BIST_MISR_EN
   input  logic              resp_in,
   input  logic              resp_valid,
   output logic [LFSR_W-1:0] signature,
`endif
   output logic              done
);

   bist_state_t       state, state_nxt;
   logic [15:0]       count;
   logic [LFSR_W-1:0] lfsr;
   logic [LFSR_W-1:0] seed_safe;
   logic              xfer;

   always_ff @(posedge I1470_clk or posedge I1477_rst) begin
      if (I1477_rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pat_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      xfer      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = SEED;
         SEED: begin
            busy      = 1'b1;
            state_nxt = (num_patterns == 16'd0) ? DONE : RUN;
         end
         RUN: begin
            busy      = 1'b1;
            pat_valid = 1'b1;
            xfer      = pat_ready;
            if (pat_ready && count == 16'd1) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge I1470_clk or posedge I1477_rst) begin
      if (I1477_rst)
         count <= '0;
      else if (state == SEED)
         count <= num_patterns;
      else if (xfer)
         count <= count - 16'd1;
   end

   // An all-zero seed would lock the LFSR, so it is remapped to 1
   always_comb seed_safe = (seed == '0) ? LFSR_W'(1) : seed;

   bist_lfsr #(
      .W       (LFSR_W),
      .RST_VAL (LFSR_W'(1))
   ) u_pat_lfsr (
      .clk      (I1470_clk),
      .rst      (I1477_rst),
      .step     (xfer),
      .load     (state == SEED),
      .load_val (seed_safe),
      .din      (1'b0),
      .q        (lfsr)
   );

   always_comb pat_data = lfsr[PAT_W-1:0];

`ifdef BIST_MISR_EN
   // Cleared on the IDLE->SEED edge; holds its value while idle so it can be read out
   bist_lfsr #(
      .W       (LFSR_W),
      .RST_VAL ('0)
   ) u_misr (
      .clk      (I1470_clk),
      .rst      (I1477_rst),
      .step     (resp_valid && (state != IDLE)),
      .load     ((state == IDLE) && start),
      .load_val ('0),
      .din      (resp_in),
      .q        (signature)
   );
`endif

endmodule

// File: tb/tb_bist_pattern_gen.sv
// Directed self-checking bench for bist_pattern_gen (MISR checks built with BIST_MISR_EN).
module tb_bist_pattern_gen;

   logic        clk       = 1'b0;
   logic        rst       = 1'b1;
   logic        start     = 1'b0;
   logic        pat_ready = 1'b0;
   logic [15:0] seed      = '0;
   logic [15:0] num       = '0;
   logic [4:0]  pat_data;
   logic        pat_valid;
   logic        busy;
   logic        done;
`ifdef BIST_MISR_EN
   logic        resp_in    = 1'b0;
   logic        resp_valid = 1'b0;
   logic [15:0] signature;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   bist_pattern_gen #(
      .LFSR_W (16),
      .PAT_W  (5)
   ) dut (
      .I1470_clk    (clk),
      .I1477_rst    (rst),
      .start        (start),
      .seed         (seed),
      .num_patterns (num),
      .pat_data     (pat_data),
      .pat_valid    (pat_valid),
      .pat_ready    (pat_ready),
      .busy         (busy),
`ifdef BIST_MISR_EN
      .resp_in      (resp_in),
      .resp_valid   (resp_valid),
      .signature    (signature),
`endif
      .done         (done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the DUT in SEED with start already released
   task automatic launch(input logic [15:0] s, input logic [15:0] n);
      seed  = s;
      num   = n;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      logic [4:0] exp_seq [6];
      int         done_seen;
      exp_seq = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h00};

      #12;
      check("rst_valid", {31'd0, pat_valid}, 32'd0);
      check("rst_busy",  {31'd0, busy},      32'd0);
      check("rst_done",  {31'd0, done},      32'd0);
      check("rst_data",  {27'd0, pat_data},  32'h01);
      rst = 1'b0;
      tick();

      // six patterns from seed 1, inputs changed after capture
      pat_ready = 1'b1;
      launch(16'h0001, 16'd6);
      check("seed_busy",  {31'd0, busy},      32'd1);
      check("seed_valid", {31'd0, pat_valid}, 32'd0);
      tick();
      seed = 16'hFFFF;
      num  = 16'd0;
      for (int i = 0; i < 6; i++) begin
         check("run6_valid", {31'd0, pat_valid}, 32'd1);
         check("run6_data",  {27'd0, pat_data},  {27'd0, exp_seq[i]});
         tick();
      end
      check("run6_done",      {31'd0, done},      32'd1);
      check("run6_valid_off", {31'd0, pat_valid}, 32'd0);
      tick();
      check("run6_done_off",  {31'd0, done},      32'd0);
      check("run6_idle_busy", {31'd0, busy},      32'd0);

      // zero seed becomes 1
      launch(16'h0000, 16'd1);
      tick();
      check("zseed_valid", {31'd0, pat_valid}, 32'd1);
      check("zseed_data",  {27'd0, pat_data},  32'h01);
      tick();
      check("zseed_done",  {31'd0, done},      32'd1);
      tick();

      // zero patterns: straight to DONE
      launch(16'h0005, 16'd0);
      check("zero_valid_seed", {31'd0, pat_valid}, 32'd0);
      tick();
      check("zero_done",       {31'd0, done},      32'd1);
      check("zero_valid_done", {31'd0, pat_valid}, 32'd0);
      tick();
      check("zero_done_off",   {31'd0, done},      32'd0);
      check("zero_busy_off",   {31'd0, busy},      32'd0);

      // stall with pat_ready 1,0,0,1 and start pulsed mid-run
      launch(16'h0001, 16'd2);
      tick();
      pat_ready = 1'b1;
      check("stall_d0", {27'd0, pat_data}, 32'h01);
      tick();
      pat_ready = 1'b0;
      start     = 1'b1;
      check("stall_d1", {27'd0, pat_data}, 32'h02);
      tick();
      check("stall_d2", {27'd0, pat_data}, 32'h02);
      check("stall_v2", {31'd0, pat_valid}, 32'd1);
      tick();
      pat_ready = 1'b1;
      start     = 1'b0;
      check("stall_d3", {27'd0, pat_data}, 32'h02);
      tick();
      check("stall_done", {31'd0, done},     32'd1);
      check("stall_lfsr", {27'd0, pat_data}, 32'h04);
      tick();
      check("stall_idle", {31'd0, busy},     32'd0);

      // reset after three of ten transfers
      launch(16'h0001, 16'd10);
      tick();
      for (int i = 0; i < 3; i++) begin
         check("abort_data", {27'd0, pat_data}, {27'd0, exp_seq[i]});
         tick();
      end
      #2 rst = 1'b1;
      #1;
      check("abort_valid", {31'd0, pat_valid}, 32'd0);
      check("abort_busy",  {31'd0, busy},      32'd0);
      check("abort_done",  {31'd0, done},      32'd0);
      check("abort_data0", {27'd0, pat_data},  32'h01);
      tick();
      rst = 1'b0;
      done_seen = 0;
      repeat (3) begin
         if (done) done_seen++;
         tick();
      end
      check("abort_no_done", done_seen, 0);
      launch(16'h0003, 16'd2);
      tick();
      check("rerun_d0", {27'd0, pat_data}, 32'h03);
      tick();
      check("rerun_d1", {27'd0, pat_data}, 32'h06);
      tick();
      check("rerun_done", {31'd0, done}, 32'd1);
      tick();

`ifdef BIST_MISR_EN
      pat_ready = 1'b0;
      launch(16'h0001, 16'd3);
      tick();
      resp_valid = 1'b1;
      resp_in    = 1'b1;
      tick();
      resp_valid = 1'b0;
      resp_in    = 1'b0;
      pat_ready  = 1'b1;
      repeat (4) tick();
      check("misr_one", {16'd0, signature}, 32'h0001);
      resp_valid = 1'b1;
      resp_in    = 1'b1;
      tick();
      check("misr_frozen", {16'd0, signature}, 32'h0001);
      resp_valid = 1'b0;
      resp_in    = 1'b0;
      launch(16'h0001, 16'd2);
      resp_valid = 1'b1;
      tick();
      repeat (3) tick();
      resp_valid = 1'b0;
      check("misr_zero", {16'd0, signature}, 32'h0000);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
